multi_ctrl: RTL
===============

# multi_ctrl

Multicycle control sequencer for the MIPS core. Drives the shared ALU, the single unified memory port, the PC/IR registers and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. Takes the one-hot instruction-class flags from the existing instruction decoder. Stalls on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rtype, ori, addi, lw, sw, lh, lhu, sh, lb, lbu, sb, beq, jump  in  1 each  decoded class flags from IR; one-hot, valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req, mem_we, iord  out  1  memory request, write, address select (0=PC, 1=ALUOut)
- ir_write, pc_en  out  1  IR load; PC load (pc_write | pc_write_cond&zero, resolved internally)
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=imm, 11=imm<<2
- alu_op  out  3  000 add, 001 sub, 010 or, 100 use funct
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- reg_write, reg_dst, mem_to_reg, imm_ext, mem_half, mem_byte, mem_ext  out  1  same meaning as single-cycle control
- illegal  out  1  one-cycle pulse: zero or multiple class flags in DECODE
- instr_done  out  1  one-cycle pulse in last state of each instruction

## Operation
- Moore FSM; outputs decode from state plus latched class only (pc_en also uses zero).
- States/transitions:
  - FETCH: mem_req, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add. Holds until mem_ready. On the mem_ready cycle, ir_write=1 and pc_en=1 with pc_source=00, then go to DECODE.
  - DECODE: alu_src_b=11, alu_op=add (branch target into ALUOut). Latch class register (R, I-arith, load, store, BR, J plus width/ext bits).
    - Not exactly one flag set: illegal=1, instr_done=1, go to FETCH.
    - Otherwise: rtype→EXEC_R, ori/addi→EXEC_I, loads/stores→ADDR, beq→BRANCH, jump→JUMP.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=100 → WB_ALU.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=010 (ori) or 000 (addi), imm_ext=addi → WB_ALU.
  - WB_ALU: reg_write=1, reg_dst=R-class, mem_to_reg=0, instr_done → FETCH.
  - ADDR: alu_src_a=1, alu_src_b=10, alu_op=add, imm_ext=1 → MEM_RD (load) or MEM_WR (store).
  - MEM_RD: mem_req, iord=1, mem_half/mem_byte/mem_ext from class. Holds until mem_ready → WB_MEM.
  - WB_MEM: reg_write=1, mem_to_reg=1, width bits held, instr_done → FETCH.
  - MEM_WR: mem_req, mem_we, iord=1, width bits. Holds until mem_ready; instr_done on the ready cycle → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01, pc_en=zero, instr_done → FETCH.
  - JUMP: pc_source=10, pc_en=1, instr_done → FETCH.
- Outputs not listed for a state are 0.
- Class register is updated only in DECODE. Flag changes in later states are ignored.

## Timing
- While rst_n=0: state=FETCH, class=0, every output forced 0, including mem_req.
- First cycle after release: FETCH with mem_req=1.
- Zero-wait cycle counts (mem_ready already high):
  - lw/lh/lhu/lb/lbu: 5
  - R/ori/addi: 4
  - sw/sh/sb: 4
  - beq/j: 3
  - illegal: 2
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle. All request outputs hold stable while waiting.
- mem_ready outside memory states is ignored.
- Reset asserted mid-access immediately drops mem_req/mem_we. No partial write is sequenced afterward.

## Structure
- Shared package multi_pkg holds:
  - state enum (4-bit, binary)
  - ALU_ADD/SUB/OR/FUNCT constants
  - ALUSRCB_* and PCSRC_* constants, also used by the datapath muxes
- One optional sub-module, multi_ctrl_out: purely combinational state+class→control decode. The FSM and class register stay in multi_ctrl.

## Test plan
- Reset released, mem_ready=1, lw flag: states FETCH,DECODE,ADDR,MEM_RD,WB_MEM. reg_write=1 & mem_to_reg=1 only in cycle 5; instr_done in cycle 5.
- sh with mem_ready low 3 cycles in MEM_WR: mem_req=mem_we=iord=1, mem_half=1 for 4 cycles; instr_done once; total 7 cycles.
- beq with zero=1, then beq with zero=0: pc_en=1 / pc_en=0 in cycle 3, pc_source=01 both.
- rtype then addi back-to-back: alu_op 100 then 000, reg_dst 1 then 0, imm_ext 0 then 1; 8 cycles total.
- DECODE with flags all 0, then with lw+sw both set: illegal pulse each time, FETCH next cycle, no reg_write/mem_we.
- rst_n dropped during MEM_WR wait: mem_req/mem_we go 0 asynchronously. After release, FETCH with mem_req=1 and iord=0.

Source files
------------

// File: rtl/multi_pkg.sv
// rtl/multi_pkg.sv - shared types and mux-select constants for the multicycle controller
package multi_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3,
        ST_WB_ALU = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_WB_MEM = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_FUNCT = 3'b100;

    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Bit positions of the decoder flags as packed by the top level.
    localparam int F_RTYPE = 0;
    localparam int F_ORI   = 1;
    localparam int F_ADDI  = 2;
    localparam int F_LW    = 3;
    localparam int F_SW    = 4;
    localparam int F_LH    = 5;
    localparam int F_LHU   = 6;
    localparam int F_SH    = 7;
    localparam int F_LB    = 8;
    localparam int F_LBU   = 9;
    localparam int F_SB    = 10;
    localparam int F_BEQ   = 11;
    localparam int F_JUMP  = 12;

    // Only what later states need; branch/jump leave DECODE straight into their own state.
    typedef struct packed {
        logic is_r;
        logic is_ori;
        logic is_addi;
        logic is_load;
        logic is_store;
        logic w_half;
        logic w_byte;
        logic w_ext;
    } class_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       imm_ext;
        logic       mem_half;
        logic       mem_byte;
        logic       mem_ext;
        logic       illegal;
        logic       instr_done;
    } ctrl_t;

    function automatic class_t decode_class(input logic [12:0] f);
        class_t c;
        c.is_r     = f[F_RTYPE];
        c.is_ori   = f[F_ORI];
        c.is_addi  = f[F_ADDI];
        c.is_load  = f[F_LW] | f[F_LH] | f[F_LHU] | f[F_LB] | f[F_LBU];
        c.is_store = f[F_SW] | f[F_SH] | f[F_SB];
        c.w_half   = f[F_LH] | f[F_LHU] | f[F_SH];
        c.w_byte   = f[F_LB] | f[F_LBU] | f[F_SB];
        c.w_ext    = f[F_LH] | f[F_LB];
        return c;
    endfunction

endpackage

// File: rtl/multi_ctrl_out.sv
// rtl/multi_ctrl_out.sv - combinational state+class to control-line decode
module multi_ctrl_out
    import multi_pkg::*;
(
    input  state_e state_i,
    input  class_t cls_i,
    input  logic   flags_onehot_i,
    input  logic   zero_i,
    input  logic   mem_ready_i,
    input  logic   active_i,
    output ctrl_t  ctrl_o
);

    ctrl_t c;
    logic  pc_write;
    logic  pc_write_cond;
    logic  mem_class;

    // Width bits only mean something for memory-class instructions.
    assign mem_class = cls_i.is_load | cls_i.is_store;

    // Moore decode; FETCH and MEM_WR look at mem_ready only for the completion strobes.
    always_comb begin
        c             = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_i)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = ALUSRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
                c.ir_write  = mem_ready_i;
                pc_write    = mem_ready_i;
            end
            ST_DECODE: begin
                c.alu_src_b  = ALUSRCB_IMM_SH2;
                c.alu_op     = ALU_ADD;
                c.illegal    = ~flags_onehot_i;
                c.instr_done = ~flags_onehot_i;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_RT;
                c.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_op    = cls_i.is_ori ? ALU_OR : ALU_ADD;
                c.imm_ext   = cls_i.is_addi;
            end
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = cls_i.is_r;
                c.instr_done = 1'b1;
            end
            ST_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.imm_ext   = 1'b1;
            end
            ST_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.mem_half = cls_i.w_half & mem_class;
                c.mem_byte = cls_i.w_byte & mem_class;
                c.mem_ext  = cls_i.w_ext & mem_class;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_half   = cls_i.w_half & mem_class;
                c.mem_byte   = cls_i.w_byte & mem_class;
                c.mem_ext    = cls_i.w_ext & mem_class;
                c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_req    = 1'b1;
                c.mem_we     = 1'b1;
                c.iord       = 1'b1;
                c.mem_half   = cls_i.w_half & mem_class;
                c.mem_byte   = cls_i.w_byte & mem_class;
                c.mem_ext    = cls_i.w_ext & mem_class;
                c.instr_done = mem_ready_i;
            end
            ST_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = ALUSRCB_RT;
                c.alu_op      = ALU_SUB;
                c.pc_source   = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                c.instr_done  = 1'b1;
            end
            ST_JUMP: begin
                c.pc_source  = PCSRC_JUMP;
                pc_write     = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        c.pc_en = pc_write | (pc_write_cond & zero_i);
        // Gating with reset makes mem_req/mem_we drop the instant reset asserts.
        ctrl_o = active_i ? c : '0;
    end

endmodule

// File: rtl/multi_ctrl.sv
// rtl/multi_ctrl.sv - multicycle MIPS control sequencer (FSM and class register)
module multi_ctrl
    import multi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rtype,
    input  logic       ori,
    input  logic       addi,
    input  logic       lw,
    input  logic       sw,
    input  logic       lh,
    input  logic       lhu,
    input  logic       sh,
    input  logic       lb,
    input  logic       lbu,
    input  logic       sb,
    input  logic       beq,
    input  logic       jump,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       imm_ext,
    output logic       mem_half,
    output logic       mem_byte,
    output logic       mem_ext,
    output logic       illegal,
    output logic       instr_done
);

    state_e      state_q, state_d;
    class_t      class_q, class_d;
    class_t      class_dec;
    logic [12:0] flags;
    logic        flags_onehot;
    ctrl_t       ctrl;

    assign flags = {jump, beq, sb, lbu, lb, sh, lhu, lh, sw, lw, addi, ori, rtype};
    assign flags_onehot = $onehot(flags);
    assign class_dec = decode_class(flags);

    // Class is captured only while in DECODE; later flag wiggles cannot disturb it.
    always_comb begin
        class_d = class_q;
        if (state_q == ST_DECODE) begin
            class_d = class_dec;
        end
    end

    // Next-state selection; DECODE dispatches on the live flags it is latching.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!flags_onehot)                         state_d = ST_FETCH;
                else if (rtype)                            state_d = ST_EXEC_R;
                else if (ori | addi)                       state_d = ST_EXEC_I;
                else if (class_dec.is_load | class_dec.is_store) state_d = ST_ADDR;
                else if (beq)                              state_d = ST_BRANCH;
                else                                       state_d = ST_JUMP;
            end
            ST_EXEC_R: state_d = ST_WB_ALU;
            ST_EXEC_I: state_d = ST_WB_ALU;
            ST_WB_ALU: state_d = ST_FETCH;
            ST_ADDR: begin
                if (class_q.is_load)       state_d = ST_MEM_RD;
                else if (class_q.is_store) state_d = ST_MEM_WR;
                else                       state_d = ST_FETCH;
            end
            ST_MEM_RD: if (mem_ready) state_d = ST_WB_MEM;
            ST_WB_MEM: state_d = ST_FETCH;
            ST_MEM_WR: if (mem_ready) state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State and class registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    multi_ctrl_out u_out (
        .state_i        (state_q),
        .cls_i          (class_q),
        .flags_onehot_i (flags_onehot),
        .zero_i         (zero),
        .mem_ready_i    (mem_ready),
        .active_i       (rst_n),
        .ctrl_o         (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign iord       = ctrl.iord;
    assign ir_write   = ctrl.ir_write;
    assign pc_en      = ctrl.pc_en;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign imm_ext    = ctrl.imm_ext;
    assign mem_half   = ctrl.mem_half;
    assign mem_byte   = ctrl.mem_byte;
    assign mem_ext    = ctrl.mem_ext;
    assign illegal    = ctrl.illegal;
    assign instr_done = ctrl.instr_done;

endmodule
